// File: rtl/wb_stage_mc.sv
// wb_stage_mc: registered write-back stage with multi-cycle load wait, timeout and flush
module wb_stage_mc #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int LD_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_flush,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic              i_rd_wren,
  input  logic [1:0]        i_wb_sel,
  input  logic [2:0]        i_ld_rewrite,
  input  logic [XLEN-1:0]   i_pc_four,
  input  logic [XLEN-1:0]   i_alu_data,
  input  logic              i_ld_valid,
  input  logic [XLEN-1:0]   i_ld_data,
  output logic              o_wb_valid,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic              o_rd_wren,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_ld_err
);
  localparam int OW = $clog2(XLEN / 8);
  localparam logic [7:0] T_LAST = 8'(LD_TIMEOUT - 1);
  typedef enum logic {IDLE, WAIT_LD} state_t;
  state_t            state;
  logic [7:0]        cnt;
  logic [REG_AW-1:0] l_rd_addr;
  logic              l_rd_wren;
  logic [2:0]        l_rw;
  logic [OW-1:0]     l_off;
  logic              accept;
  logic              ld_wait;
  logic [XLEN-1:0]   ld_ext;
  logic [XLEN-1:0]   sel_data;
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d, input logic [2:0] rw,
                                              input logic [OW-1:0] off);
    logic [XLEN-1:0] sb, sh, sw;
    logic [7:0]      b;
    logic [15:0]     h;
    logic [31:0]     w;
    sb = d >> (8 * int'(off));
    sh = d >> (16 * (int'(off) >> 1));
    sw = d >> (32 * (int'(off) >> 2));
    b = sb[7:0];
    h = sh[15:0];
    w = sw[31:0];
    return rw == 3'd0 ? XLEN'($signed(b)) :
           rw == 3'd1 ? XLEN'($signed(h)) :
           rw == 3'd2 ? XLEN'($signed(w)) :
           rw == 3'd3 ? XLEN'(b) :
           rw == 3'd4 ? XLEN'(h) :
           rw == 3'd5 ? XLEN'(w) :
           rw == 3'd6 ? (XLEN == 64 ? d : XLEN'($signed(w))) : d;
  endfunction
  assign o_ready  = state == IDLE;
  assign accept   = i_valid && o_ready && !i_flush;
  assign ld_wait  = i_wb_sel == 2'd2 && !i_ld_valid;
  // In IDLE the extractor serves a load completing in its accept cycle
  assign ld_ext   = state == IDLE ? extract(i_ld_data, i_ld_rewrite, i_alu_data[OW-1:0])
                                  : extract(i_ld_data, l_rw, l_off);
  assign sel_data = i_wb_sel == 2'd0 ? i_pc_four :
                    i_wb_sel == 2'd1 ? i_alu_data :
                    i_wb_sel == 2'd2 ? ld_ext : '0;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      o_wb_valid <= 1'b0;
      o_rd_wren  <= 1'b0;
      o_ld_err   <= 1'b0;
      o_rd_addr  <= '0;
      o_wb_data  <= '0;
    end else begin
      o_wb_valid <= 1'b0;
      o_rd_wren  <= 1'b0;
      o_ld_err   <= 1'b0;
      o_rd_addr  <= '0;
      if (state == IDLE) begin
        if (accept && !ld_wait) begin
          o_wb_valid <= 1'b1;
          o_rd_addr  <= i_rd_addr;
          o_rd_wren  <= i_rd_wren && i_rd_addr != '0;
          o_wb_data  <= sel_data;
        end else if (accept) begin
          state     <= WAIT_LD;
          cnt       <= '0;
          l_rd_addr <= i_rd_addr;
          l_rd_wren <= i_rd_wren && i_rd_addr != '0;
          l_rw      <= i_ld_rewrite;
          l_off     <= i_alu_data[OW-1:0];
        end
      end else if (i_flush) begin
        state <= IDLE;
      end else if (i_ld_valid) begin
        state      <= IDLE;
        o_wb_valid <= 1'b1;
        o_rd_addr  <= l_rd_addr;
        o_rd_wren  <= l_rd_wren;
        o_wb_data  <= ld_ext;
      end else if (cnt == T_LAST) begin
        state    <= IDLE;
        o_ld_err <= 1'b1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage_mc.sv
// tb_wb_stage_mc: directed and randomized checks of wb_stage_mc against a transaction-level model
module tb_wb_stage_mc;
  localparam int TMO = 4;
  logic        clk = 1'b0;
  logic        rst, valid, flush, rd_wren, ld_valid;
  logic        ready, wb_valid, o_wren, ld_err;
  logic [4:0]  rd_addr, o_addr;
  logic [1:0]  wb_sel;
  logic [2:0]  rw;
  logic [31:0] pc_four, alu, ld_data, wb_data;
  int tests = 0;
  int fails = 0;
  bit checking = 0;

  wb_stage_mc #(.XLEN(32), .REG_AW(5), .LD_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready), .i_flush(flush),
    .i_rd_addr(rd_addr), .i_rd_wren(rd_wren), .i_wb_sel(wb_sel), .i_ld_rewrite(rw),
    .i_pc_four(pc_four), .i_alu_data(alu), .i_ld_valid(ld_valid), .i_ld_data(ld_data),
    .o_wb_valid(wb_valid), .o_rd_addr(o_addr), .o_rd_wren(o_wren), .o_wb_data(wb_data),
    .o_ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [31:0] d, input int t, input int off);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (t)
      0: return b >= 32'd128 ? b + 32'hFFFF_FF00 : b;
      1: return h >= 32'd32768 ? h + 32'hFFFF_0000 : h;
      3: return b;
      4: return h;
      default: return d;
    endcase
  endfunction

  // Transaction-level model: one pending load at most, counting idle wait cycles
  bit          busy;
  int          waited;
  logic [4:0]  p_rd;
  bit          p_wren;
  int          p_rw, p_off;
  logic        e_valid, e_wren, e_err;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  always @(posedge clk) begin
    e_valid = 0; e_wren = 0; e_err = 0; e_addr = 0;
    if (rst) begin
      busy = 0;
      e_data = 0;
    end else if (!busy) begin
      if (valid && !flush) begin
        if (wb_sel != 2 || ld_valid) begin
          e_valid = 1;
          e_addr = rd_addr;
          e_wren = rd_wren && rd_addr != 0;
          e_data = wb_sel == 0 ? pc_four : wb_sel == 1 ? alu :
                   wb_sel == 2 ? m_ext(ld_data, int'(rw), int'(alu[1:0])) : 32'd0;
        end else begin
          busy = 1; waited = 0;
          p_rd = rd_addr; p_wren = rd_wren && rd_addr != 0;
          p_rw = int'(rw); p_off = int'(alu[1:0]);
        end
      end
    end else if (flush) begin
      busy = 0;
    end else if (ld_valid) begin
      busy = 0;
      e_valid = 1; e_addr = p_rd; e_wren = p_wren;
      e_data = m_ext(ld_data, p_rw, p_off);
    end else begin
      waited++;
      if (waited == TMO) begin
        busy = 0;
        e_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("ready", 32'(ready), 32'(!busy));
      chk("wb_valid", 32'(wb_valid), 32'(e_valid));
      chk("rd_wren", 32'(o_wren), 32'(e_wren));
      chk("rd_addr", 32'(o_addr), 32'(e_addr));
      chk("ld_err", 32'(ld_err), 32'(e_err));
      chk("wb_data", wb_data, e_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 0; valid = 0; flush = 0; rd_addr = 0; rd_wren = 0; wb_sel = 0; rw = 0;
    pc_four = 0; alu = 0; ld_valid = 0; ld_data = 0;
  endtask

  task automatic ld_accept(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd);
    clr();
    valid = 1; wb_sel = 2; rw = t; alu = a; rd_addr = rd; rd_wren = 1;
    cyc();
    clr();
  endtask

  initial begin
    clr();
    rst = 1;
    cyc();
    checking = 1;
    cyc();
    clr();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_data", wb_data, 32'd0);
    // reset while a load is pending
    ld_accept(3'd0, 32'h3, 5'd9);
    cyc();
    chk("wait_ready", 32'(ready), 32'd0);
    rst = 1;
    cyc();
    rst = 0;
    chk("rstw_ready", 32'(ready), 32'd1);
    chk("rstw_valid", 32'(wb_valid), 32'd0);
    chk("rstw_err", 32'(ld_err), 32'd0);
    repeat (TMO + 2) cyc();
    // ALU, pc+4 and zero selects
    valid = 1; wb_sel = 1; alu = 32'h1234; rd_addr = 5; rd_wren = 1;
    cyc();
    chk("alu_valid", 32'(wb_valid), 32'd1);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_wren", 32'(o_wren), 32'd1);
    rd_addr = 0;
    cyc();
    chk("alu_r0_wren", 32'(o_wren), 32'd0);
    wb_sel = 0; pc_four = 32'h100; rd_addr = 4;
    cyc();
    chk("pc4_data", wb_data, 32'h100);
    wb_sel = 3;
    cyc();
    chk("zero_data", wb_data, 32'd0);
    flush = 1; wb_sel = 1;
    cyc();
    chk("iflush_valid", 32'(wb_valid), 32'd0);
    chk("iflush_hold", wb_data, 32'd0);
    // LB / LBU waiting three cycles
    for (int k = 0; k < 2; k++) begin
      ld_accept(k == 0 ? 3'd0 : 3'd3, 32'h1003, 5'd7);
      chk("lb_ready1", 32'(ready), 32'd0);
      cyc();
      chk("lb_ready2", 32'(ready), 32'd0);
      cyc();
      chk("lb_ready3", 32'(ready), 32'd0);
      ld_valid = 1; ld_data = 32'h80FF_0000;
      cyc();
      clr();
      chk("lb_valid", 32'(wb_valid), 32'd1);
      chk("lb_data", wb_data, k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      chk("lb_ready", 32'(ready), 32'd1);
    end
    // LH completing in its accept cycle
    valid = 1; wb_sel = 2; rw = 1; alu = 32'h2002; rd_addr = 3; rd_wren = 1;
    ld_valid = 1; ld_data = 32'h8001_7FFF;
    cyc();
    clr();
    chk("lh_valid", 32'(wb_valid), 32'd1);
    chk("lh_data", wb_data, 32'hFFFF_8001);
    // timeout
    ld_accept(3'd2, 32'h0, 5'd6);
    for (int k = 0; k < TMO - 1; k++) begin
      cyc();
      chk("tmo_noerr", 32'(ld_err), 32'd0);
    end
    cyc();
    chk("tmo_err", 32'(ld_err), 32'd1);
    chk("tmo_valid", 32'(wb_valid), 32'd0);
    chk("tmo_wren", 32'(o_wren), 32'd0);
    cyc();
    chk("tmo_err_clr", 32'(ld_err), 32'd0);
    chk("tmo_ready", 32'(ready), 32'd1);
    // data on the last allowed wait cycle is a success
    ld_accept(3'd4, 32'h2, 5'd8);
    repeat (TMO - 1) cyc();
    ld_valid = 1; ld_data = 32'hBEEF_0000;
    cyc();
    clr();
    chk("edge_valid", 32'(wb_valid), 32'd1);
    chk("edge_err", 32'(ld_err), 32'd0);
    chk("edge_data", wb_data, 32'h0000_BEEF);
    // flush in WAIT_LD with coincident data, then a new ALU op
    ld_accept(3'd0, 32'h1, 5'd2);
    flush = 1; ld_valid = 1; ld_data = 32'h1111_1111;
    cyc();
    clr();
    chk("fl_valid", 32'(wb_valid), 32'd0);
    chk("fl_err", 32'(ld_err), 32'd0);
    chk("fl_ready", 32'(ready), 32'd1);
    valid = 1; wb_sel = 1; alu = 32'hABCD; rd_addr = 3; rd_wren = 1;
    cyc();
    clr();
    chk("fl_alu_valid", 32'(wb_valid), 32'd1);
    chk("fl_alu_data", wb_data, 32'hABCD);
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom_range(0, 99) == 0;
      valid = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 9) == 0;
      rd_addr = 5'($urandom_range(0, 31));
      rd_wren = 1'($urandom);
      wb_sel = 2'($urandom);
      rw = 3'($urandom);
      pc_four = $urandom;
      alu = $urandom;
      ld_valid = $urandom_range(0, 9) < 3;
      ld_data = $urandom;
      cyc();
    end
    clr();
    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_stage_mc.md
Name: wb_stage_mc

Overview:
- Parametrised, registered successor of the combinational write-back stage.
- Accepts one retiring instruction per handshake from MEM.
- Performs load-data extraction and sign/zero extension for XLEN 32 or 64.
- Waits a variable number of cycles for load data, with timeout and flush support.
- Presents a registered, one-cycle-valid register-file write to the regfile and forwarding logic.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- LD_TIMEOUT, 15, max cycles spent in WAIT_LD before abort; legal range 1..255.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  MEM presents an instruction.
- o_ready  out  1  stage can accept; 1 only in IDLE.
- i_flush  in  1  kill the pending instruction.
- i_rd_addr  in  REG_AW  destination register.
- i_rd_wren  in  1  instruction writes rd.
- i_wb_sel  in  2  0 = pc+4, 1 = ALU, 2 = load, 3 = zero.
- i_ld_rewrite  in  3  load type (encoding below).
- i_pc_four  in  XLEN  pc+4.
- i_alu_data  in  XLEN  ALU result / load address.
- i_ld_valid  in  1  load data returned this cycle.
- i_ld_data  in  XLEN  raw aligned memory word.
- o_wb_valid  out  1  one-cycle write strobe.
- o_rd_addr  out  REG_AW  write address.
- o_rd_wren  out  1  regfile write enable (qualified).
- o_wb_data  out  XLEN  write data.
- o_ld_err  out  1  one-cycle pulse on load timeout.

Behaviour:
- Reset: state = IDLE, timeout counter = 0. o_ready = 1 from the first cycle after reset. o_wb_valid, o_rd_wren, o_ld_err, o_rd_addr, o_wb_data all reset to 0. Reset wins over every other input, including mid-WAIT_LD; a pending load is dropped.
- Accept: handshake is i_valid && o_ready && !i_flush.
- Non-load accept (i_wb_sel != 2):
  - Registered result next cycle: o_wb_valid = 1 for exactly one cycle (latency 1).
  - o_wb_data selected by i_wb_sel; sel 3 gives 0.
  - o_rd_addr = i_rd_addr.
  - o_rd_wren = i_rd_wren && (i_rd_addr != 0).
- Load accept (i_wb_sel == 2):
  - If i_ld_valid is also 1 that cycle, complete as a non-load (latency 1).
  - Otherwise latch rd_addr, rd_wren, rewrite and the offset bits of i_alu_data, then enter WAIT_LD; o_ready = 0.
- WAIT_LD:
  - Each cycle with i_ld_valid = 1: next cycle o_wb_valid = 1 with the extracted data; return to IDLE. o_ready is 1 in the cycle after completion.
  - i_ld_valid is ignored in IDLE unless coincident with a load accept.
  - Counter increments each cycle without i_ld_valid. When it reaches LD_TIMEOUT, the next cycle gives o_ld_err = 1, o_wb_valid = 0 and o_rd_wren = 0, then IDLE.
  - i_ld_valid in the same cycle the counter hits the limit counts as success.
- Flush:
  - In IDLE, a flush blocks acceptance.
  - In WAIT_LD, a flush returns to IDLE next cycle with no write and no error; i_ld_valid in that same cycle is discarded.
- Load extraction:
  - off = latched address bits [log2(XLEN/8)-1:0].
  - Byte lane = off; halfword lane = off >> 1; word lane = off >> 2.
  - i_ld_rewrite encoding:
    - 0 = LB, sign-extend.
    - 1 = LH, sign-extend.
    - 2 = LW, sign-extend to XLEN.
    - 3 = LBU, zero-extend.
    - 4 = LHU, zero-extend.
    - 5 = LWU, zero-extend.
    - 6 = LD: full word at XLEN = 64; treated as 2 at XLEN = 32.
    - 7 = raw i_ld_data.
  - Low bits below the access size are ignored (no misalign trap).
- Outputs are cleared to 0 on every cycle without a write strobe. o_wb_data holds its last value.

Test Plan:
- Reset during WAIT_LD (load accepted, i_ld_valid low), i_reset = 1 for 1 cycle -> o_ready = 1 next cycle, no o_wb_valid, no o_ld_err.
- ALU op: i_wb_sel = 1, i_alu_data = 0x0000_1234, rd = 5 -> next cycle o_wb_valid = 1, o_wb_data = 0x0000_1234, o_rd_wren = 1; with rd = 0, o_rd_wren = 0.
- LB, addr 0x...3, data returns 3 cycles later as 0x80FF_0000 -> o_ready low for 3 cycles, then o_wb_data = 0xFFFF_FF80. LBU on the same data -> 0x0000_0080.
- LH, addr offset 2, i_ld_valid coincident with accept, data 0x8001_7FFF -> latency 1, o_wb_data = 0xFFFF_8001.
- Timeout: LD_TIMEOUT = 4, no i_ld_valid -> o_ld_err pulse after 4 wait cycles, o_wb_valid = 0, o_ready = 1 the following cycle.
- Flush in WAIT_LD with i_ld_valid = 1 the same cycle -> no write, no error. A new ALU op is accepted on the next cycle and written normally.
